// File: rtl/exu_gpr_file.sv
// -----------------------------------------------------------------------------
// exu_gpr_file
//
// Integer register file x0..x31 with two combinational read ports and one
// write port. x0 is hardwired to zero and is not stored.
//
// After reset a clear sequencer zeroes x1..x31, one register per cycle,
// through the single array write port. This models a 1W RAM that cannot be
// flash-cleared. o_rdy rises once the last register has been cleared. EXU
// issue is expected to stall while o_rdy is low.
//
// Each read port returns the write port's data in the same cycle when the
// addresses match (write-first bypass). An idle port (vld=0) returns zero.
//
// Ports
//   i_clk            clock, all state updates on posedge
//   i_rst            synchronous active-high reset; (re)starts the clear
//   i_gpr_r1_vld     read port 1 valid
//   i_gpr_r1_addr    read port 1 register address
//   o_gpr_r1_data    read port 1 data (combinational)
//   i_gpr_r2_vld     read port 2 valid
//   i_gpr_r2_addr    read port 2 register address
//   o_gpr_r2_data    read port 2 data (combinational)
//   i_gpr_w_wen      write enable
//   i_gpr_w_addr     write register address (x0 writes are dropped)
//   i_gpr_w_data     write data
//   o_rdy            high once the post-reset clear has finished
// -----------------------------------------------------------------------------
module exu_gpr_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // Read port 1
  input  logic            i_gpr_r1_vld,
  input  logic [AW-1:0]   i_gpr_r1_addr,
  output logic [XLEN-1:0] o_gpr_r1_data,
  // Read port 2
  input  logic            i_gpr_r2_vld,
  input  logic [AW-1:0]   i_gpr_r2_addr,
  output logic [XLEN-1:0] o_gpr_r2_data,
  // Write port
  input  logic            i_gpr_w_wen,
  input  logic [AW-1:0]   i_gpr_w_addr,
  input  logic [XLEN-1:0] i_gpr_w_data,
  // Status
  output logic            o_rdy
);

  localparam int unsigned NREGS = 2 ** AW;
  localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FirstIdx = AW'(1);

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StRun   = 2'd1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [AW-1:0]   r_clr_idx;
  logic            r_rdy;

  // x0 is not stored; index range starts at 1.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  // ---------------------------------------------------------------------------
  // Array write port: shared by the clear sequencer and the architectural
  // write port. Nothing is written in a cycle where reset is sampled.
  // ---------------------------------------------------------------------------
  logic            w_run;
  logic            w_arch_wr;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic [XLEN-1:0] w_wr_data;

  assign w_run     = (r_state == StRun) && !i_rst;
  assign w_arch_wr = w_run && i_gpr_w_wen && (i_gpr_w_addr != '0);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = FirstIdx;
    w_wr_data = '0;
    if (!i_rst) begin
      if (r_state == StClear) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_clr_idx;
        w_wr_data = '0;
      end else if (w_arch_wr) begin
        w_wr_en   = 1'b1;
        w_wr_addr = i_gpr_w_addr;
        w_wr_data = i_gpr_w_data;
      end
    end
  end

  // RAM-style storage, no reset: contents are cleared by the sequencer.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer / mode FSM. o_rdy is registered and rises on the same
  // edge that writes the last register, so exit always precedes index wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StClear;
      r_clr_idx <= FirstIdx;
      r_rdy     <= 1'b0;
    end else begin
      unique case (r_state)
        StClear: begin
          if (r_clr_idx == LastIdx) begin
            r_state <= StRun;
            r_rdy   <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + FirstIdx;
          end
        end
        StRun: begin
          r_rdy <= 1'b1;
        end
        default: begin
          r_state   <= StClear;
          r_clr_idx <= FirstIdx;
          r_rdy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdy = r_rdy;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Stored value for an address; x0 reads zero without touching the array.
  logic [XLEN-1:0] w_r1_stored;
  logic [XLEN-1:0] w_r2_stored;
  logic            w_r1_byp;
  logic            w_r2_byp;

  assign w_r1_stored = (i_gpr_r1_addr == '0) ? '0 : r_regs[i_gpr_r1_addr];
  assign w_r2_stored = (i_gpr_r2_addr == '0) ? '0 : r_regs[i_gpr_r2_addr];

  // w_arch_wr already excludes x0, so a bypass can never leak x0 writes.
  assign w_r1_byp = w_arch_wr && (i_gpr_w_addr == i_gpr_r1_addr);
  assign w_r2_byp = w_arch_wr && (i_gpr_w_addr == i_gpr_r2_addr);

  // Idle ports and every read outside RUN return zero so downstream logic
  // does not toggle.
  always_comb begin
    o_gpr_r1_data = '0;
    if (w_run && i_gpr_r1_vld && (i_gpr_r1_addr != '0)) begin
      o_gpr_r1_data = w_r1_byp ? i_gpr_w_data : w_r1_stored;
    end
  end

  always_comb begin
    o_gpr_r2_data = '0;
    if (w_run && i_gpr_r2_vld && (i_gpr_r2_addr != '0)) begin
      o_gpr_r2_data = w_r2_byp ? i_gpr_w_data : w_r2_stored;
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  a_r1_known: assert property (@(posedge i_clk) disable iff (i_rst)
    ((r_state == StRun) && i_gpr_r1_vld && !$isunknown(i_gpr_r1_addr))
      |-> !$isunknown(o_gpr_r1_data));

  a_r2_known: assert property (@(posedge i_clk) disable iff (i_rst)
    ((r_state == StRun) && i_gpr_r2_vld && !$isunknown(i_gpr_r2_addr))
      |-> !$isunknown(o_gpr_r2_data));

  a_wen_known: assert property (@(posedge i_clk) disable iff (i_rst)
    r_rdy |-> !$isunknown(i_gpr_w_wen));

endmodule

// File: tb/tb_exu_gpr_file.sv
module tb_exu_gpr_file;

  logic        clk;
  logic        rst;
  logic        r1_vld;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;
  logic        r2_vld;
  logic [4:0]  r2_addr;
  logic [31:0] r2_data;
  logic        w_wen;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        rdy;

  int n_pass;
  int n_total;

  // Reference: architectural view of the register file.
  logic [31:0] model [32];
  bit          model_rdy;

  exu_gpr_file #(
    .XLEN(32),
    .AW  (5)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_gpr_r1_vld (r1_vld),
    .i_gpr_r1_addr(r1_addr),
    .o_gpr_r1_data(r1_data),
    .i_gpr_r2_vld (r2_vld),
    .i_gpr_r2_addr(r2_addr),
    .o_gpr_r2_data(r2_data),
    .i_gpr_w_wen  (w_wen),
    .i_gpr_w_addr (w_addr),
    .i_gpr_w_data (w_data),
    .o_rdy        (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic vld, input logic [4:0] a);
    if (!vld || !model_rdy || a == 5'd0) return 32'h0;
    if (w_wen && w_addr == a) return w_data;
    return model[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of the cycle just checked, taken at the next edge.
  task automatic commit();
    if (model_rdy && !rst && w_wen && w_addr != 5'd0) model[w_addr] = w_data;
  endtask

  // Reset for one cycle and watch the clear. Optionally inject a write to x3
  // during clear cycle 10.
  task automatic do_reset(input bit inject);
    int cnt;
    bit done;
    step();
    rst    = 1'b1;
    w_wen  = 1'b0;
    r1_vld = 1'b1;
    r2_vld = 1'b1;
    @(negedge clk);
    step();
    rst       = 1'b0;
    model_rdy = 0;
    cnt       = 0;
    done      = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (i != 0) step();
      r1_vld  = 1'b1;
      r1_addr = 5'($urandom);
      r2_vld  = 1'($urandom);
      r2_addr = 5'($urandom);
      if (inject && cnt == 10) begin
        w_wen  = 1'b1;
        w_addr = 5'd3;
        w_data = 32'hFFFF_FFFF;
      end else begin
        w_wen = 1'b0;
      end
      @(negedge clk);
      if (rdy === 1'b1) begin
        done = 1;
      end else begin
        cnt++;
        n_total++;
        if (r1_data !== 32'h0)
          $display("FAIL clear_r1_zero: cycle %0d got %h want 00000000", cnt, r1_data);
        else n_pass++;
        n_total++;
        if (r2_data !== 32'h0)
          $display("FAIL clear_r2_zero: cycle %0d got %h want 00000000", cnt, r2_data);
        else n_pass++;
      end
    end
    w_wen = 1'b0;
    n_total++;
    if (cnt !== 31 || !done)
      $display("FAIL clear_len: rdy low for %0d cycles (rose=%0d) want 31", cnt, done);
    else n_pass++;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    model_rdy = 1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 1; i < 32; i++) begin
      step();
      w_wen   = 1'b0;
      r1_vld  = 1'b1;
      r1_addr = 5'(i);
      r2_vld  = 1'b1;
      r2_addr = 5'(32 - i);
      @(negedge clk);
      n_total++;
      if (r1_data !== 32'h0)
        $display("FAIL %s_r1: x%0d got %h want 00000000", tag, i, r1_data);
      else n_pass++;
      n_total++;
      if (r2_data !== 32'h0)
        $display("FAIL %s_r2: x%0d got %h want 00000000", tag, 32 - i, r2_data);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_total++;
    if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy);
    else n_pass++;
    check_all_zero("reset_read");
  endtask

  task automatic test_write_read();
    step();
    w_wen  = 1'b1;
    w_addr = 5'd5;
    w_data = 32'hDEAD_BEEF;
    r1_vld = 1'b0;
    r2_vld = 1'b0;
    @(negedge clk);
    commit();
    step();
    w_wen   = 1'b0;
    r1_vld  = 1'b1;
    r1_addr = 5'd5;
    r2_vld  = 1'b1;
    r2_addr = 5'd0;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'hDEAD_BEEF) $display("FAIL wr_rd_x5: got %h want deadbeef", r1_data);
    else n_pass++;
    n_total++;
    if (r2_data !== 32'h0) $display("FAIL wr_rd_x0: got %h want 00000000", r2_data);
    else n_pass++;
  endtask

  task automatic test_x0();
    for (int i = 0; i < 4; i++) begin
      step();
      w_wen   = (i == 0);
      w_addr  = 5'd0;
      w_data  = 32'h1234_5678;
      r1_vld  = 1'b1;
      r1_addr = 5'd0;
      r2_vld  = 1'b1;
      r2_addr = 5'd0;
      @(negedge clk);
      n_total++;
      if (r1_data !== 32'h0) $display("FAIL x0_r1: cycle %0d got %h want 00000000", i, r1_data);
      else n_pass++;
      n_total++;
      if (r2_data !== 32'h0) $display("FAIL x0_r2: cycle %0d got %h want 00000000", i, r2_data);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_bypass();
    step();
    w_wen   = 1'b1;
    w_addr  = 5'd7;
    w_data  = 32'hA5A5_A5A5;
    r1_vld  = 1'b1;
    r1_addr = 5'd7;
    r2_vld  = 1'b1;
    r2_addr = 5'd7;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'hA5A5_A5A5) $display("FAIL bypass_r1: got %h want a5a5a5a5", r1_data);
    else n_pass++;
    n_total++;
    if (r2_data !== 32'hA5A5_A5A5) $display("FAIL bypass_r2: got %h want a5a5a5a5", r2_data);
    else n_pass++;
    commit();
    step();
    w_wen  = 1'b1;
    w_addr = 5'd9;
    w_data = 32'h0BAD_F00D;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'hA5A5_A5A5) $display("FAIL bypass_hold: got %h want a5a5a5a5", r1_data);
    else n_pass++;
    commit();
  endtask

  task automatic test_idle_and_xdata();
    // Idle ports read zero even on a stored nonzero register and on bypass.
    step();
    w_wen   = 1'b1;
    w_addr  = 5'd7;
    w_data  = 32'h1111_2222;
    r1_vld  = 1'b0;
    r1_addr = 5'd7;
    r2_vld  = 1'b0;
    r2_addr = 5'd5;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'h0) $display("FAIL idle_r1: got %h want 00000000", r1_data);
    else n_pass++;
    n_total++;
    if (r2_data !== 32'h0) $display("FAIL idle_r2: got %h want 00000000", r2_data);
    else n_pass++;
    commit();
    // Unknown data with wen low must leave x5 intact.
    step();
    w_wen  = 1'b0;
    w_addr = 5'd5;
    w_data = 32'hxxxx_xxxx;
    @(negedge clk);
    commit();
    step();
    w_data  = 32'h0;
    r1_vld  = 1'b1;
    r1_addr = 5'd5;
    r2_vld  = 1'b1;
    r2_addr = 5'd7;
    @(negedge clk);
    n_total++;
    if (r1_data !== model[5]) $display("FAIL xdata_x5: got %h want %h", r1_data, model[5]);
    else n_pass++;
    n_total++;
    if (r2_data !== 32'h1111_2222) $display("FAIL idle_wr_x7: got %h want 11112222", r2_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 0; i < 400; i++) begin
      step();
      w_wen   = 1'($urandom);
      w_addr  = 5'($urandom);
      w_data  = $urandom;
      r1_vld  = ($urandom_range(0, 7) != 0);
      r2_vld  = ($urandom_range(0, 7) != 0);
      r1_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom);
      r2_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom);
      @(negedge clk);
      e1 = exp_rd(r1_vld, r1_addr);
      e2 = exp_rd(r2_vld, r2_addr);
      n_total++;
      if (r1_data !== e1) $display("FAIL rand_r1: it %0d x%0d got %h want %h", i, r1_addr, r1_data, e1);
      else n_pass++;
      n_total++;
      if (r2_data !== e2) $display("FAIL rand_r2: it %0d x%0d got %h want %h", i, r2_addr, r2_data, e2);
      else n_pass++;
      commit();
    end
  endtask

  task automatic test_clear_writes();
    do_reset(1'b1);
    step();
    w_wen   = 1'b0;
    r1_vld  = 1'b1;
    r1_addr = 5'd3;
    r2_vld  = 1'b1;
    r2_addr = 5'd3;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'h0) $display("FAIL clear_wr_x3: got %h want 00000000", r1_data);
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    for (int i = 1; i < 32; i++) begin
      step();
      w_wen   = 1'b1;
      w_addr  = 5'(i);
      w_data  = i * 32'h0101_0101;
      r1_vld  = 1'b1;
      r1_addr = 5'(i);
      r2_vld  = 1'b1;
      r2_addr = 5'(i - 1);
      @(negedge clk);
      n_total++;
      if (r2_data !== exp_rd(1'b1, 5'(i - 1)))
        $display("FAIL fill_prev: x%0d got %h want %h", i - 1, r2_data, exp_rd(1'b1, 5'(i - 1)));
      else n_pass++;
      commit();
    end
    step();
    w_wen   = 1'b0;
    r1_addr = 5'd31;
    @(negedge clk);
    n_total++;
    if (r1_data !== 32'h1F1F_1F1F) $display("FAIL fill_x31: got %h want 1f1f1f1f", r1_data);
    else n_pass++;
    do_reset(1'b0);
    check_all_zero("midrun_read");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    r1_vld  = 1'b0;
    r1_addr = '0;
    r2_vld  = 1'b0;
    r2_addr = '0;
    w_wen   = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    model_rdy = 0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;

    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_idle_and_xdata();
    test_random();
    test_clear_writes();
    test_random();
    test_midrun_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
